turn_queue: RTL

Direction front-end for the snake/dragon game: takes the debounced button levels and the move tick, and turns presses into a buffered, reversal-safe stream of one-hot turns. It sits between the `debounce` instances / `updateClk` and the game-state logic. It replaces the bare direction register and also owns start, pause and game-over sequencing. Downstream advances the head only on `step`, using `direction`.

---
 rtl/turn_queue_if.sv | 33 +++
 rtl/turn_queue.sv | 139 +++++++++++++
 2 files changed

// File: rtl/turn_queue_if.sv
// Button/tick inputs and direction-stream outputs between the debouncers and game logic.
// The slave side is the turn queue; the master side drives buttons and observes turns.
interface turn_queue_if #(
    parameter int DEPTH = 4
);
    logic                     up;
    logic                     down;
    logic                     left;
    logic                     right;
    logic                     enter;
    logic                     update;
    logic                     start;
    logic                     game_over;
    logic [3:0]               direction;
    logic                     step;
    logic                     paused;
    logic [$clog2(DEPTH):0]   queue_count;
    logic                     dropped;

    modport master (
        output up, down, left, right, enter,
        output update, start, game_over,
        input  direction, step, paused,
        input  queue_count, dropped
    );

    modport slave (
        input  up, down, left, right, enter,
        input  update, start, game_over,
        output direction, step, paused,
        output queue_count, dropped
    );
endinterface

// File: rtl/turn_queue.sv
// Buffered, reversal-safe one-hot turn queue with start/pause/game-over sequencing.
// Presses become FIFO entries; each move tick pops the head into the live direction.
module turn_queue #(
    parameter int         DEPTH    = 4,
    parameter logic [3:0] INIT_DIR = 4'b1000
) (
    input  logic         pixel_clk,
    input  logic         reset,
    turn_queue_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE,
        OVER
    } state_e;

    state_e          state_q, state_d;
    logic [4:0]      prev_q;
    logic [4:0]      lvl, edg;
    logic [3:0]      fifo_q [DEPTH];
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic [3:0]      dir_q, dir_d;
    logic            step_q, step_d;
    logic            drop_q, drop_d;
    logic [3:0]      cand, ref_dir, opp;
    logic            run_st, pause_st;
    logic            pop, push, full, empty, rej;

    assign lvl = {bus.enter, bus.right, bus.left, bus.down, bus.up};
    assign edg = lvl & ~prev_q;

    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!bus.start) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:  state_d = RUN;
                RUN: begin
                    if (bus.game_over)  state_d = OVER;
                    else if (edg[4])    state_d = PAUSE;
                end
                PAUSE: begin
                    if (bus.game_over)  state_d = OVER;
                    else if (edg[4])    state_d = RUN;
                end
                OVER:  state_d = OVER;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        run_st   = (state_q == RUN);
        pause_st = (state_q == PAUSE);
    end

    always_comb begin
        cand = 4'b0000;
        if (edg[0])       cand = 4'b0001;
        else if (edg[1])  cand = 4'b0010;
        else if (edg[2])  cand = 4'b0100;
        else if (edg[3])  cand = 4'b1000;

        empty   = (count_q == '0);
        full    = (count_q == CW'(DEPTH));
        ref_dir = empty ? dir_q : fifo_q[tail_q - PW'(1)];
        // Swapping the bit pairs maps up<->down and left<->right.
        opp     = {ref_dir[2], ref_dir[3], ref_dir[0], ref_dir[1]};

        pop     = run_st && bus.update && !empty;
        rej     = (cand == ref_dir) || (cand == opp) || (full && !pop);
        push    = run_st && (cand != 4'b0000) && !rej;
        drop_d  = run_st && (cand != 4'b0000) && rej;
        step_d  = run_st && bus.update;

        head_d  = pop  ? head_q + PW'(1) : head_q;
        tail_d  = push ? tail_q + PW'(1) : tail_q;
        count_d = count_q + CW'(push) - CW'(pop);
        dir_d   = pop ? fifo_q[head_q] : dir_q;

        if (!bus.start || state_q == IDLE) begin
            pop     = 1'b0;
            push    = 1'b0;
            drop_d  = 1'b0;
            step_d  = 1'b0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            dir_d   = INIT_DIR;
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            prev_q  <= '1;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            dir_q   <= INIT_DIR;
            step_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            prev_q  <= lvl;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            dir_q   <= dir_d;
            step_q  <= step_d;
            drop_q  <= drop_d;
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (push) begin
            fifo_q[tail_q] <= cand;
        end
    end

    assign bus.direction   = dir_q;
    assign bus.step        = step_q;
    assign bus.paused      = pause_st;
    assign bus.queue_count = count_q;
    assign bus.dropped     = drop_q;
endmodule
